stream_demux: RTL
=================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, payload width in bits (>=1).
REQ-002 The block SHALL have parameter NUM_CH, default 6, number of output channels (2..64, not required to be a power of 2).
REQ-003 The block SHALL have parameter SEL_W, default $clog2(NUM_CH), select width, derived and never overridden.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, input transfer request.
REQ-007 The block SHALL have port in_ready, output, 1, the block can accept the current input.
REQ-008 The block SHALL have port in_data, input, DATA_W, input payload.
REQ-009 The block SHALL have port in_sel, input, SEL_W, destination channel index.
REQ-010 The block SHALL have port flush, input, 1, synchronous discard of the held entry.
REQ-011 The block SHALL have port out_valid, output, NUM_CH, one-hot or zero per-channel valid.
REQ-012 The block SHALL have port out_ready, input, NUM_CH, per-channel ready.
REQ-013 The block SHALL have port out_data, output, DATA_W, shared payload bus common to all channels.
REQ-014 The block SHALL have port drop, output, 1, one-cycle pulse when an out-of-range input is discarded.
REQ-015 The block SHALL have port err_cnt, output, 8, saturating count of drops (see Configuration).

Function
REQ-016 The block SHALL hold one registered entry (data, channel, valid); an input is accepted on a cycle where in_valid && in_ready.
REQ-017 in_ready SHALL be high when (!held_valid || out_ready[held_ch]) && !flush.
REQ-018 An accepted input with in_sel < NUM_CH SHALL appear on out_data with out_valid[in_sel]=1 on the next cycle; latency is exactly 1 cycle.
REQ-019 At most one out_valid bit SHALL be high at any time; all bits SHALL be 0 when no entry is held.
REQ-020 The held entry SHALL complete on a cycle where out_valid[held_ch] && out_ready[held_ch]; ready bits of other channels SHALL be ignored.
REQ-021 Completion and a new acceptance in the same cycle SHALL replace the entry with no bubble, sustaining one transfer per cycle.
REQ-022 out_data and the channel SHALL remain stable while out_valid is high and out_ready[held_ch] is low.
REQ-023 An accepted input with in_sel >= NUM_CH SHALL be consumed and not registered, and SHALL pulse drop for the next cycle only; a held entry completing that cycle SHALL still clear.
REQ-024 flush=1 SHALL clear held_valid at the next edge, forcing in_ready=0 that cycle; flush SHALL take priority over completion and acceptance.
REQ-025 out_data SHALL hold its last value when no entry is held; it is don't-care to the consumer.

Reset
REQ-026 reset_n low SHALL asynchronously clear held_valid, out_valid, drop, err_cnt, out_data and the held channel to 0.
REQ-027 Reset asserted mid-transfer SHALL discard the held entry with no completion reported.
REQ-028 Reset release SHALL be synchronous to clock, and in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-029 Macro STREAM_DEMUX_ERRCNT_EN defined: err_cnt SHALL increment on each drop pulse and saturate at 255; only reset clears it.
REQ-030 Macro STREAM_DEMUX_ERRCNT_EN undefined: err_cnt SHALL be tied to 0 with no counter logic; drop SHALL behave identically.

Verification
REQ-031 The bench SHALL check basic routing: NUM_CH=6, in_sel=3, in_data=0xA5, out_ready=all ones -> next cycle out_valid=6'b001000, out_data=0xA5.
REQ-032 The bench SHALL check backpressure: entry held on channel 2 with out_ready[2]=0 for 4 cycles and out_ready[5]=1 -> in_ready=0 and out_data stable for all 4 cycles, then completion on the cycle out_ready[2] rises.
REQ-033 The bench SHALL check throughput: 8 back-to-back inputs cycling channels 0..5 with all ready -> 8 transfers in 8 consecutive cycles, in order.
REQ-034 The bench SHALL check out-of-range select: in_sel=7 with NUM_CH=6 -> out_valid stays 0, one drop pulse, and err_cnt=1 with the macro or 0 without it; 300 drops -> err_cnt=255.
REQ-035 The bench SHALL check flush priority: entry held, flush=1 with in_valid=1 and out_ready=all ones -> in_ready=0, the next cycle has out_valid=0, and the input is not accepted.
REQ-036 The bench SHALL check reset mid-operation: reset_n pulled low asynchronously with an entry held -> out_valid=0 immediately, and in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux
// Purpose  : One-entry registered demux that steers a ready/valid stream onto
//            one of NUM_CH channels over a shared data bus; out-of-range
//            selects are dropped. STREAM_DEMUX_ERRCNT_EN enables err_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 6,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              flush,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              drop,
  output logic [7:0]        err_cnt
);

  localparam logic [SEL_W:0] C_NUM_CH = (SEL_W + 1)'(NUM_CH);

  logic              r_held_valid;
  logic [SEL_W-1:0]  r_held_ch;
  logic [DATA_W-1:0] r_data;
  logic [NUM_CH-1:0] r_out_valid;
  logic              r_drop;

  logic              w_in_range;
  logic              w_complete;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_drop_next;
  logic [NUM_CH-1:0] w_onehot;

  assign w_in_range  = ({1'b0, in_sel} < C_NUM_CH);
  assign w_complete  = r_held_valid && out_ready[r_held_ch];
  assign w_in_ready  = (!r_held_valid || w_complete) && !flush;
  assign w_accept    = in_valid && w_in_ready;
  assign w_drop_next = w_accept && !w_in_range;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_sel == SEL_W'(i)) w_onehot[i] = 1'b1;
    end
  end

  // Flush outranks everything; an out-of-range accept falls through to the
  // completion branch so a finishing entry still clears.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_held_valid <= 1'b0;
      r_held_ch    <= '0;
      r_data       <= '0;
      r_out_valid  <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_drop <= w_drop_next;
      if (flush) begin
        r_held_valid <= 1'b0;
        r_out_valid  <= '0;
      end else if (w_accept && w_in_range) begin
        r_held_valid <= 1'b1;
        r_held_ch    <= in_sel;
        r_data       <= in_data;
        r_out_valid  <= w_onehot;
      end else if (w_complete) begin
        r_held_valid <= 1'b0;
        r_out_valid  <= '0;
      end
    end
  end

`ifdef STREAM_DEMUX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_drop_next && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;
  assign drop      = r_drop;

endmodule
`default_nettype wire
